// File: rtl/axi_wr_pkg.sv
// Shared widths, response codes and beat/response layouts for the write responder.
package axi_wr_pkg;

  localparam int ID_WIDTH   = 3;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_beat_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [1:0]          resp;
  } wr_resp_t;

  localparam int BEAT_WIDTH = $bits(wr_beat_t);
  localparam int RESP_WIDTH = $bits(wr_resp_t);

endpackage

// File: rtl/resp_queue.sv
// Circular FIFO with one extra pointer bit so full and empty are distinguishable.
module resp_queue #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[PW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (PW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign count     = wr_ptr - rd_ptr;
  assign head_data = mem[rd_ptr[PW-1:0]];

endmodule

// File: rtl/axi_wr_responder.sv
// Write-stream responder: decodes each beat, commits OKAY writes to local storage
// and returns an in-order {id, resp} per beat through a small response queue.
module axi_wr_responder
  import axi_wr_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int RQ_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [BEAT_WIDTH-1:0]      in_AXI,
  input  logic                       svalid,
  output logic                       sready,
  output logic [ID_WIDTH-1:0]        out_id,
  output logic [1:0]                 out_resp,
  output logic                       bvalid,
  input  logic                       bready,
  input  logic [$clog2(DEPTH)-1:0]   peek_idx,
  output logic [DATA_WIDTH-1:0]      peek_data,
  output logic [15:0]                ok_cnt
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(RQ_DEPTH) + 1;

  wr_beat_t              beat;
  wr_resp_t              push_resp;
  wr_resp_t              head_resp;
  logic [DATA_WIDTH-1:0] storage [DEPTH];
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_next;
  logic                  full;
  logic                  empty;
  logic                  accept;
  logic                  pop;
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_idx;

  assign beat   = in_AXI;
  assign accept = svalid && sready && !full;
  assign pop    = bready && !empty;
  assign wr_idx = beat.addr[2 +: IDX_W];

  always_comb begin
    push_resp.id   = beat.id;
    push_resp.resp = RESP_OKAY;
    wr_en          = 1'b0;
    if (beat.addr[1:0] != 2'b00) begin
      push_resp.resp = RESP_SLVERR;
    end else if (beat.addr[ADDR_WIDTH-1:2] >= (ADDR_WIDTH-2)'(DEPTH)) begin
      push_resp.resp = RESP_DECERR;
    end else begin
      wr_en = 1'b1;
    end
  end

  resp_queue #(
    .WIDTH (RESP_WIDTH),
    .DEPTH (RQ_DEPTH)
  ) u_resp_queue (
    .clk       (clk),
    .rstn      (rstn),
    .push      (accept),
    .push_data (push_resp),
    .pop       (pop),
    .head_data (head_resp),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // sready is registered from the next occupancy, so it never depends
  // combinationally on svalid/bready and stays low throughout reset.
  assign count_next = count + CNT_W'(accept) - CNT_W'(pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sready <= 1'b0;
      ok_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) storage[i] <= '0;
    end else begin
      sready <= (count_next < CNT_W'(RQ_DEPTH));
      if (accept && wr_en) begin
        storage[wr_idx] <= beat.data;
        if (ok_cnt != 16'hFFFF) ok_cnt <= ok_cnt + 16'd1;
      end
    end
  end

  assign bvalid    = !empty;
  assign out_id    = head_resp.id;
  assign out_resp  = head_resp.resp;
  assign peek_data = storage[peek_idx];

endmodule

// File: tb/tb_axi_wr_responder.sv
// Self-checking bench for axi_wr_responder: vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_axi_wr_responder;
  import axi_wr_pkg::*;

  localparam int DEPTH    = 16;
  localparam int RQ_DEPTH = 2;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic [BEAT_WIDTH-1:0] in_AXI;
  logic                  svalid;
  logic                  sready;
  logic [ID_WIDTH-1:0]   out_id;
  logic [1:0]            out_resp;
  logic                  bvalid;
  logic                  bready;
  logic [3:0]            peek_idx;
  logic [31:0]           peek_data;
  logic [15:0]           ok_cnt;

  axi_wr_responder #(.DEPTH(DEPTH), .RQ_DEPTH(RQ_DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_AXI    (in_AXI),
    .svalid    (svalid),
    .sready    (sready),
    .out_id    (out_id),
    .out_resp  (out_resp),
    .bvalid    (bvalid),
    .bready    (bready),
    .peek_idx  (peek_idx),
    .peek_data (peek_data),
    .ok_cnt    (ok_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  id;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  exp_resp;
    logic [3:0]  idx;
    logic [31:0] exp_peek;
    logic [15:0] exp_ok;
  } vec_t;

  vec_t        vecs [10];
  logic [31:0] m_mem [DEPTH];
  wr_resp_t    m_q [$];
  int          m_ok;
  bit          m_started;
  int          checks   = 0;
  int          failures = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic bit expSready();
    return m_started && (m_q.size() < RQ_DEPTH);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_q.delete();
    m_ok      = 0;
    m_started = 0;
  endtask

  task automatic modelAccept(input logic [2:0] id, input logic [31:0] addr, input logic [31:0] data);
    wr_resp_t r;
    r.id = id;
    if (addr % 4 != 0) begin
      r.resp = RESP_SLVERR;
    end else if (addr / 4 >= DEPTH) begin
      r.resp = RESP_DECERR;
    end else begin
      r.resp = RESP_OKAY;
      m_mem[addr / 4] = data;
      if (m_ok < 65535) m_ok++;
    end
    m_q.push_back(r);
  endtask

  task automatic modelCheck();
    checkOutput("bvalid", bvalid, m_q.size() > 0);
    checkOutput("sready", sready, expSready());
    checkOutput("ok_cnt", ok_cnt, m_ok);
    checkOutput("peek_data", peek_data, m_mem[peek_idx]);
    if (m_q.size() > 0) begin
      checkOutput("out_id", out_id, m_q[0].id);
      checkOutput("out_resp", out_resp, m_q[0].resp);
    end
  endtask

  // One clock: drive, check before the edge, advance the model across the edge.
  task automatic applyStimulus(input bit v, input logic [2:0] id, input logic [31:0] addr,
                               input logic [31:0] data, input bit br);
    bit acc;
    bit pop;
    svalid = v;
    in_AXI = {id, addr, data};
    bready = br;
    @(negedge clk);
    modelCheck();
    @(posedge clk);
    acc = v && expSready();
    pop = br && (m_q.size() > 0);
    if (pop) void'(m_q.pop_front());
    if (acc) modelAccept(id, addr, data);
    m_started = 1;
    #1;
  endtask

  initial begin
    vecs[0] = '{3'd1, 32'h0000_0000, 32'h0000_00A5, RESP_OKAY,   4'd0,  32'h0000_00A5, 16'd1};
    vecs[1] = '{3'd2, 32'h0000_0004, 32'h0000_0001, RESP_OKAY,   4'd1,  32'h0000_0001, 16'd2};
    vecs[2] = '{3'd3, 32'h0000_0008, 32'h0000_0002, RESP_OKAY,   4'd2,  32'h0000_0002, 16'd3};
    vecs[3] = '{3'd4, 32'h0000_000C, 32'h0000_0003, RESP_OKAY,   4'd3,  32'h0000_0003, 16'd4};
    vecs[4] = '{3'd5, 32'h0000_0006, 32'h0000_0077, RESP_SLVERR, 4'd1,  32'h0000_0001, 16'd4};
    vecs[5] = '{3'd6, 32'h0000_0040, 32'h0000_0088, RESP_DECERR, 4'd0,  32'h0000_00A5, 16'd4};
    vecs[6] = '{3'd7, 32'h0000_0008, 32'h0000_0005, RESP_OKAY,   4'd2,  32'h0000_0005, 16'd5};
    vecs[7] = '{3'd0, 32'h0000_0008, 32'h0000_0009, RESP_OKAY,   4'd2,  32'h0000_0009, 16'd6};
    vecs[8] = '{3'd2, 32'hFFFF_FFFC, 32'h0000_0001, RESP_DECERR, 4'd15, 32'h0000_0000, 16'd6};
    vecs[9] = '{3'd3, 32'h0000_003C, 32'hDEAD_BEEF, RESP_OKAY,   4'd15, 32'hDEAD_BEEF, 16'd7};

    rstn = 1'b0; svalid = 1'b0; bready = 1'b0; in_AXI = '0; peek_idx = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst bvalid", bvalid, 0);
    checkOutput("rst sready", sready, 0);
    checkOutput("rst out_id", out_id, 0);
    checkOutput("rst out_resp", out_resp, 0);
    checkOutput("rst ok_cnt", ok_cnt, 0);
    checkOutput("rst peek", peek_data, 0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checkOutput("release sready low", sready, 0);
    @(posedge clk);
    #1;
    m_started = 1;
    checkOutput("release sready high", sready, 1);

    // Back-to-back table with bready held high.
    for (int i = 0; i < 10; i++) begin
      peek_idx = vecs[i].idx;
      applyStimulus(1'b1, vecs[i].id, vecs[i].addr, vecs[i].data, 1'b1);
      checkOutput("tbl bvalid", bvalid, 1);
      checkOutput("tbl out_id", out_id, vecs[i].id);
      checkOutput("tbl out_resp", out_resp, vecs[i].exp_resp);
      checkOutput("tbl peek", peek_data, vecs[i].exp_peek);
      checkOutput("tbl ok_cnt", ok_cnt, vecs[i].exp_ok);
      checkOutput("tbl sready", sready, 1);
    end
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);

    // Backpressure: queue fills after two beats, third waits for a pop.
    peek_idx = 4'd4;
    applyStimulus(1'b1, 3'd5, 32'h10, 32'h11, 1'b0);
    applyStimulus(1'b1, 3'd6, 32'h14, 32'h22, 1'b0);
    checkOutput("bp full sready", sready, 0);
    checkOutput("bp head id", out_id, 5);
    applyStimulus(1'b1, 3'd7, 32'h18, 32'h33, 1'b0);
    checkOutput("bp held id", out_id, 5);
    checkOutput("bp held bvalid", bvalid, 1);
    applyStimulus(1'b1, 3'd7, 32'h18, 32'h33, 1'b1);
    checkOutput("bp sready after pop", sready, 1);
    checkOutput("bp second id", out_id, 6);
    applyStimulus(1'b1, 3'd7, 32'h18, 32'h33, 1'b1);
    checkOutput("bp third id", out_id, 7);
    repeat (2) applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    checkOutput("bp drained", bvalid, 0);

    // Reset with two responses pending.
    peek_idx = 4'd8;
    applyStimulus(1'b1, 3'd1, 32'h20, 32'h55, 1'b0);
    applyStimulus(1'b1, 3'd2, 32'h24, 32'h66, 1'b0);
    checkOutput("pre-reset peek", peek_data, 32'h55);
    #2;
    rstn = 1'b0;
    #1;
    modelReset();
    checkOutput("mid-rst bvalid", bvalid, 0);
    checkOutput("mid-rst sready", sready, 0);
    checkOutput("mid-rst peek", peek_data, 0);
    checkOutput("mid-rst ok_cnt", ok_cnt, 0);
    svalid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checkOutput("re-release sready low", sready, 0);
    @(posedge clk);
    #1;
    m_started = 1;
    checkOutput("re-release sready high", sready, 1);
    checkOutput("re-release no stale", bvalid, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] addr;
      int          sel;
      sel = $urandom_range(0, 9);
      if (sel < 7)       addr = 32'($urandom_range(0, DEPTH - 1)) * 4;
      else if (sel == 7) addr = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
      else if (sel == 8) addr = ($urandom | 32'h40) & ~32'h3;
      else               addr = $urandom;
      peek_idx = 4'($urandom_range(0, DEPTH - 1));
      applyStimulus($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), addr, $urandom,
                    $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
